// File: rtl/lsu_pkg.sv
// Shared encodings, FSM state type and byte-enable helper for the load/store unit.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  // Wide enough for two dword beats (2 * 8 lanes)
  localparam int unsigned MASK_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    WB
  } lsu_state_t;

  // Two-beat byte mask: (2^bytes - 1) << off
  function automatic logic [MASK_W-1:0] be_mask(input logic [1:0] size, input logic [2:0] off);
    logic [MASK_W-1:0] ones;
    ones = MASK_W'((17'd1 << (4'd1 << size)) - 17'd1);
    return ones << off;
  endfunction

endpackage

// File: rtl/lsu_split_align.sv
// Lane shifting: store data into byte lanes, load data out of a two-beat buffer with extension.
module lsu_align #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0]             st_wdata,
  input  logic [$clog2(XLEN/8)-1:0]   st_off,
  output logic [2*XLEN-1:0]           st_data,
  input  logic [2*XLEN-1:0]           ld_buf,
  input  logic [$clog2(XLEN/8)-1:0]   ld_off,
  input  logic [1:0]                  ld_size,
  input  logic                        ld_unsigned,
  output logic [XLEN-1:0]             ld_data
);

  localparam int unsigned DW = 2 * XLEN;
  localparam int unsigned IW = $clog2(XLEN);

  logic [XLEN-1:0] ld_low;
  int unsigned     nbits;
  logic            sign;

  assign st_data = DW'(st_wdata) << {st_off, 3'b000};
  assign ld_low  = XLEN'(ld_buf >> {ld_off, 3'b000});

  // Width of the loaded field and the bit used to fill above it
  always_comb begin
    nbits = 32'd8 << ld_size;
    if (nbits > XLEN) nbits = XLEN;
    sign = ~ld_unsigned & ld_low[IW'(nbits - 32'd1)];
  end

  for (genvar i = 0; i < XLEN; i++) begin : g_ext
    assign ld_data[i] = (32'(i) < nbits) ? ld_low[i] : sign;
  end

endmodule

// File: rtl/lsu_split.sv
// Load/store unit: valid/ready request in, request/grant/response memory beats out,
// boundary-crossing accesses split into two aligned beats, loads extended for writeback.
module lsu_split
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter bit          MISALIGN_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [1:0]           req_size_i,
  input  logic                 req_unsigned_i,
  input  logic [ADDR_W-1:0]    req_addr_i,
  input  logic [XLEN-1:0]      req_wdata_i,
  input  logic [4:0]           req_rd_i,
  output logic                 mem_req_o,
  input  logic                 mem_gnt_i,
  output logic                 mem_we_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic [XLEN/8-1:0]    mem_be_o,
  output logic [XLEN-1:0]      mem_wdata_o,
  input  logic                 mem_rvalid_i,
  input  logic [XLEN-1:0]      mem_rdata_i,
  output logic                 wb_valid_o,
  output logic [4:0]           wb_rd_o,
  output logic [XLEN-1:0]      wb_data_o,
  output logic                 err_misalign_o
);

  localparam int unsigned NB   = XLEN / 8;
  localparam int unsigned OFFW = $clog2(NB);
  localparam int unsigned DW   = 2 * XLEN;
  localparam int unsigned MW   = 2 * NB;

  lsu_state_t        state;
  logic              we_q;
  logic              uns_q;
  logic              split_q;
  logic              beat_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [4:0]        rd_q;
  logic [DW-1:0]     rbuf_q;

  logic              in_idle;
  logic [ADDR_W-1:0] addr_m;
  logic [1:0]        size_m;
  logic [OFFW-1:0]   off_m;
  logic [ADDR_W-1:0] base_m;
  logic [MW-1:0]     mask_m;
  logic [XLEN-1:0]   wdata_m;
  logic [3:0]        bytes_c;
  logic              split_c;
  logic              illegal_c;
  logic [DW-1:0]     st_data;
  logic [DW-1:0]     buf_nxt;
  logic [XLEN-1:0]   ld_data;

  // Beat 0 is set up from the live request, beat 1 from the latched one
  assign in_idle = (state == IDLE);
  assign addr_m  = in_idle ? req_addr_i  : addr_q;
  assign size_m  = in_idle ? req_size_i  : size_q;
  assign wdata_m = in_idle ? req_wdata_i : wdata_q;
  assign off_m   = addr_m[OFFW-1:0];
  assign base_m  = addr_m & ~ADDR_W'(NB - 1);
  assign mask_m  = MW'(be_mask(size_m, 3'(off_m)));

  assign bytes_c   = 4'd1 << req_size_i;
  assign split_c   = (5'(req_addr_i[OFFW-1:0]) + 5'(bytes_c)) > 5'(NB);
  assign illegal_c = ((!MISALIGN_EN) && ((req_addr_i & ADDR_W'(bytes_c - 4'd1)) != '0)) ||
                     ((req_size_i == SZ_D) && (XLEN == 32));

  assign buf_nxt = beat_q ? {mem_rdata_i, rbuf_q[XLEN-1:0]} : {rbuf_q[DW-1:XLEN], mem_rdata_i};

  lsu_align #(.XLEN(XLEN)) u_align (
    .st_wdata    (wdata_m),
    .st_off      (off_m),
    .st_data     (st_data),
    .ld_buf      (buf_nxt),
    .ld_off      (addr_q[OFFW-1:0]),
    .ld_size     (size_q),
    .ld_unsigned (uns_q),
    .ld_data     (ld_data)
  );

  // Control FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      we_q           <= 1'b0;
      uns_q          <= 1'b0;
      split_q        <= 1'b0;
      beat_q         <= 1'b0;
      size_q         <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      rd_q           <= '0;
      rbuf_q         <= '0;
      req_ready_o    <= 1'b1;
      mem_req_o      <= 1'b0;
      mem_we_o       <= 1'b0;
      mem_addr_o     <= '0;
      mem_be_o       <= '0;
      mem_wdata_o    <= '0;
      wb_valid_o     <= 1'b0;
      wb_rd_o        <= '0;
      wb_data_o      <= '0;
      err_misalign_o <= 1'b0;
    end else begin
      wb_valid_o     <= 1'b0;
      err_misalign_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid_i && req_ready_o) begin
            we_q    <= req_we_i;
            uns_q   <= req_unsigned_i;
            size_q  <= req_size_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            rd_q    <= req_rd_i;
            split_q <= split_c;
            beat_q  <= 1'b0;
            if (illegal_c) begin
              err_misalign_o <= 1'b1;
            end else begin
              state       <= ISSUE;
              req_ready_o <= 1'b0;
              mem_req_o   <= 1'b1;
              mem_we_o    <= req_we_i;
              mem_addr_o  <= base_m;
              mem_be_o    <= mask_m[NB-1:0];
              mem_wdata_o <= st_data[XLEN-1:0];
            end
          end
        end
        ISSUE: begin
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid_i) begin
            if (!we_q) rbuf_q <= buf_nxt;
            if (split_q && !beat_q) begin
              beat_q      <= 1'b1;
              state       <= ISSUE;
              mem_req_o   <= 1'b1;
              mem_addr_o  <= base_m + ADDR_W'(NB);
              mem_be_o    <= mask_m[MW-1:NB];
              mem_wdata_o <= st_data[DW-1:XLEN];
            end else if (!we_q) begin
              state      <= WB;
              wb_valid_o <= (rd_q != 5'd0);
              wb_rd_o    <= rd_q;
              wb_data_o  <= ld_data;
            end else begin
              state       <= IDLE;
              req_ready_o <= 1'b1;
            end
          end
        end
        WB: begin
          state       <= IDLE;
          req_ready_o <= 1'b1;
        end
        default: begin
          state       <= IDLE;
          req_ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_split.sv
// Bench for lsu_split: byte-level memory responder plus a flat byte-array reference model.
module tb_lsu_split;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ADDR_W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid_i, req_valid0, req_we_i, req_unsigned_i;
  logic [1:0]  req_size_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [4:0]  req_rd_i;
  logic        req_ready_o, mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i, wb_valid_o, err_misalign_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i, wb_data_o;
  logic [3:0]  mem_be_o;
  logic [4:0]  wb_rd_o;

  logic        ready0, mem_req0, mem_we0, wb_valid0, err0;
  logic [31:0] mem_addr0, mem_wdata0, wb_data0;
  logic [3:0]  mem_be0;
  logic [4:0]  wb_rd0;
  logic        gnt0 = 1'b0, rvalid0 = 1'b0;
  logic [31:0] rdata0 = '0;

  lsu_split #(.XLEN(XLEN), .ADDR_W(ADDR_W), .MISALIGN_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_we_i(req_we_i), .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_rd_i(req_rd_i),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o),
    .wb_data_o(wb_data_o), .err_misalign_o(err_misalign_o));

  lsu_split #(.XLEN(XLEN), .ADDR_W(ADDR_W), .MISALIGN_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid0), .req_ready_o(ready0),
    .req_we_i(req_we_i), .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_rd_i(req_rd_i),
    .mem_req_o(mem_req0), .mem_gnt_i(gnt0), .mem_we_o(mem_we0), .mem_addr_o(mem_addr0),
    .mem_be_o(mem_be0), .mem_wdata_o(mem_wdata0), .mem_rvalid_i(rvalid0),
    .mem_rdata_i(rdata0), .wb_valid_o(wb_valid0), .wb_rd_o(wb_rd0),
    .wb_data_o(wb_data0), .err_misalign_o(err0));

  int checks = 0;
  int failures = 0;

  // Memory contents (responder) and the model's own view of memory
  logic [7:0] mem [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction
  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return dflt(a);
  endfunction
  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return dflt(a);
  endfunction
  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
    int n;
    logic [63:0] v;
    n = 1 << sz;
    v = '0;
    for (int i = 0; i < n; i++) v = v | (64'(ref_rd(a + 32'(i))) << (8 * i));
    if (!uns && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
    return v[31:0];
  endfunction
  task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    for (int i = 0; i < (1 << sz); i++) ref_mem[a + 32'(i)] = wd[8*i +: 8];
  endtask
  task automatic preset(input logic [31:0] a, input logic [7:0] v);
    mem[a] = v;
    ref_mem[a] = v;
  endtask

  // Responder knobs, beat log and protocol observations
  int gmin = 0, gmax = 0, rmin = 0, rmax = 0;
  bit rv_pend = 1'b0;
  int rv_cnt, stall, req_cycles, last_req_cycles;
  int unstable = 0, overlap = 0;
  logic [31:0] rv_data;
  bit have_snap = 1'b0;
  logic [31:0] snap_addr, snap_wdata;
  logic [3:0] snap_be;
  logic snap_we;
  logic [31:0] log_addr[$], log_wdata[$];
  logic [3:0] log_be[$];
  logic log_we[$];

  initial begin : responder
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      mem_gnt_i = 1'b0;
      mem_rvalid_i = 1'b0;
      if (rv_pend) begin
        if (mem_req_o) overlap++;
        if (rv_cnt == 0) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i = rv_data;
          rv_pend = 1'b0;
        end else rv_cnt--;
      end else if (mem_req_o) begin
        if (!have_snap) begin
          have_snap = 1'b1;
          snap_addr = mem_addr_o; snap_be = mem_be_o; snap_we = mem_we_o; snap_wdata = mem_wdata_o;
          stall = $urandom_range(gmax, gmin);
          req_cycles = 0;
        end else if (snap_addr !== mem_addr_o || snap_be !== mem_be_o ||
                     snap_we !== mem_we_o || snap_wdata !== mem_wdata_o) begin
          unstable++;
        end
        req_cycles++;
        if (stall == 0) begin
          mem_gnt_i = 1'b1;
          log_addr.push_back(mem_addr_o); log_be.push_back(mem_be_o);
          log_we.push_back(mem_we_o); log_wdata.push_back(mem_wdata_o);
          if (mem_we_o) begin
            for (int i = 0; i < 4; i++)
              if (mem_be_o[i]) mem[mem_addr_o + 32'(i)] = mem_wdata_o[8*i +: 8];
            rv_data = $urandom;
          end else begin
            rv_data = {mem_rd(mem_addr_o + 32'd3), mem_rd(mem_addr_o + 32'd2),
                       mem_rd(mem_addr_o + 32'd1), mem_rd(mem_addr_o)};
          end
          rv_pend = 1'b1;
          rv_cnt = $urandom_range(rmax, rmin);
          have_snap = 1'b0;
          last_req_cycles = req_cycles;
        end else stall--;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic clear_log();
    log_addr.delete(); log_be.delete(); log_we.delete(); log_wdata.delete();
  endtask

  task automatic set_lat(input int g0, input int g1, input int r0, input int r1);
    gmin = g0; gmax = g1; rmin = r0; rmax = r1;
  endtask

  // Handshake completes on the posedge inside this task; next negedge is cycle 1
  task automatic send(input bit to0, input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
    @(negedge clk);
    req_we_i = we; req_size_i = sz; req_unsigned_i = uns;
    req_addr_i = a; req_wdata_i = wd; req_rd_i = rd;
    if (to0) req_valid0 = 1'b1; else req_valid_i = 1'b1;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    req_valid0 = 1'b0;
  endtask

  task automatic wait_done(output logic wbv, output logic [4:0] wrd, output logic [31:0] wd,
                           output int wbk, output int cyc, output int errs, output bit tmo);
    wbv = 1'b0; wrd = '0; wd = '0; wbk = 0; cyc = 0; errs = 0; tmo = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (err_misalign_o) errs++;
      if (wb_valid_o && !wbv) begin
        wbv = 1'b1; wrd = wb_rd_o; wd = wb_data_o; wbk = k;
      end
      if (req_ready_o) begin
        cyc = k; tmo = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (req_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", req_ready_o); end
    checks++; if ({mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o} !== '0) begin
      failures++; $display("FAIL reset_mem got=%b/%b/%h/%h/%h want=0", mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o); end
    checks++; if ({wb_valid_o, wb_rd_o, wb_data_o, err_misalign_o} !== '0) begin
      failures++; $display("FAIL reset_wb got=%b/%h/%h/%b want=0", wb_valid_o, wb_rd_o, wb_data_o, err_misalign_o); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (req_ready_o !== 1'b1 || mem_req_o !== 1'b0) begin
      failures++; $display("FAIL reset_release got ready=%b req=%b want 1/0", req_ready_o, mem_req_o); end
  endtask

  task automatic test_lw_timing();
    logic wbv; logic [4:0] wrd; logic [31:0] wd; int wbk, cyc, errs; bit tmo;
    set_lat(0, 0, 0, 0);
    preset(32'h100, 8'hBB); preset(32'h101, 8'hAA); preset(32'h102, 8'h99); preset(32'h103, 8'h88);
    clear_log();
    send(0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 5'd5);
    wait_done(wbv, wrd, wd, wbk, cyc, errs, tmo);
    checks++; if (tmo || cyc != 4) begin failures++; $display("FAIL lw_ready_cycle got=%0d tmo=%0d want=4", cyc, tmo); end
    checks++; if (wbk != 3) begin failures++; $display("FAIL lw_wb_cycle got=%0d want=3", wbk); end
    checks++; if (wd !== 32'h8899AABB || wrd !== 5'd5) begin failures++; $display("FAIL lw_data got=%h rd=%0d want=8899aabb rd=5", wd, wrd); end
    checks++; if (log_addr.size() != 1 || log_addr[0] !== 32'h100 || log_be[0] !== 4'hF || log_we[0] !== 1'b0) begin
      failures++; $display("FAIL lw_beat got beats=%0d want one beat addr=100 be=f we=0", log_addr.size()); end
  endtask

  task automatic test_lb();
    logic wbv; logic [4:0] wrd; logic [31:0] wd; int wbk, cyc, errs; bit tmo;
    set_lat(0, 2, 0, 2);
    preset(32'h100, 8'h00); preset(32'h101, 8'h00); preset(32'h102, 8'h00); preset(32'h103, 8'h80);
    clear_log();
    send(0, 1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 5'd7);
    wait_done(wbv, wrd, wd, wbk, cyc, errs, tmo);
    checks++; if (!wbv || wd !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_signed got=%h wbv=%b want=ffffff80", wd, wbv); end
    checks++; if (log_be.size() != 1 || log_be[0] !== 4'b1000) begin failures++; $display("FAIL lb_be got beats=%0d want be=1000", log_be.size()); end
    send(0, 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 5'd7);
    wait_done(wbv, wrd, wd, wbk, cyc, errs, tmo);
    checks++; if (!wbv || wd !== 32'h00000080) begin failures++; $display("FAIL lbu got=%h wbv=%b want=00000080", wd, wbv); end
  endtask

  task automatic test_store();
    logic wbv; logic [4:0] wrd; logic [31:0] wd; int wbk, cyc, errs; bit tmo;
    set_lat(0, 0, 0, 0);
    clear_log();
    ref_store(32'h108, 2'd2, 32'h01020304);
    send(0, 1'b1, 2'd2, 1'b0, 32'h108, 32'h01020304, 5'd1);
    wait_done(wbv, wrd, wd, wbk, cyc, errs, tmo);
    checks++; if (tmo || cyc != 3 || wbv) begin failures++; $display("FAIL sw_ready_cycle got=%0d wbv=%b want=3 wbv=0", cyc, wbv); end
    clear_log();
    ref_store(32'h102, 2'd2, 32'hDEADBEEF);
    send(0, 1'b1, 2'd2, 1'b0, 32'h102, 32'hDEADBEEF, 5'd1);
    wait_done(wbv, wrd, wd, wbk, cyc, errs, tmo);
    checks++; if (log_addr.size() != 2) begin failures++; $display("FAIL sw_split_beats got=%0d want=2", log_addr.size()); end
    else begin
      checks++; if (log_addr[0] !== 32'h100 || log_be[0] !== 4'b1100 || log_wdata[0] !== 32'hBEEF0000 || log_we[0] !== 1'b1) begin
        failures++; $display("FAIL sw_beat0 got addr=%h be=%b wd=%h want 100/1100/beef0000", log_addr[0], log_be[0], log_wdata[0]); end
      checks++; if (log_addr[1] !== 32'h104 || log_be[1] !== 4'b0011 || log_wdata[1] !== 32'h0000DEAD || log_we[1] !== 1'b1) begin
        failures++; $display("FAIL sw_beat1 got addr=%h be=%b wd=%h want 104/0011/0000dead", log_addr[1], log_be[1], log_wdata[1]); end
    end
    set_lat(0, 2, 0, 2);
    send(0, 1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 5'd2);
    wait_done(wbv, wrd, wd, wbk, cyc, errs, tmo);
    checks++; if (!wbv || wd !== 32'hDEADBEEF) begin failures++; $display("FAIL sw_readback got=%h want=deadbeef", wd); end
  endtask

  task automatic test_lh_split();
    logic wbv; logic [4:0] wrd; logic [31:0] wd; int wbk, cyc, errs; bit tmo;
    set_lat(0, 0, 0, 0);
    preset(32'h103, 8'h12); preset(32'h104, 8'h34);
    clear_log();
    send(0, 1'b0, 2'd1, 1'b0, 32'h103, 32'h0, 5'd9);
    wait_done(wbv, wrd, wd, wbk, cyc, errs, tmo);
    checks++; if (!wbv || wd !== 32'h00003412) begin failures++; $display("FAIL lh_split_data got=%h want=00003412", wd); end
    checks++; if (wbk != 5 || cyc != 6) begin failures++; $display("FAIL lh_split_timing got wb=%0d ready=%0d want 5/6", wbk, cyc); end
    checks++; if (log_addr.size() != 2 || log_addr[0] !== 32'h100 || log_addr[1] !== 32'h104 ||
                  log_be[0] !== 4'b1000 || log_be[1] !== 4'b0001) begin
      failures++; $display("FAIL lh_split_beats got n=%0d want 100/1000 then 104/0001", log_addr.size()); end
  endtask

  task automatic test_wrap();
    logic wbv; logic [4:0] wrd; logic [31:0] wd; int wbk, cyc, errs; bit tmo;
    logic [31:0] exp;
    set_lat(0, 1, 0, 1);
    preset(32'hFFFFFFFE, 8'h11); preset(32'hFFFFFFFF, 8'h22); preset(32'h0, 8'h33); preset(32'h1, 8'h44);
    exp = ref_load(32'hFFFFFFFE, 2'd2, 1'b0);
    clear_log();
    send(0, 1'b0, 2'd2, 1'b0, 32'hFFFFFFFE, 32'h0, 5'd4);
    wait_done(wbv, wrd, wd, wbk, cyc, errs, tmo);
    checks++; if (!wbv || wd !== exp) begin failures++; $display("FAIL wrap_data got=%h want=%h", wd, exp); end
    checks++; if (log_addr.size() != 2 || log_addr[0] !== 32'hFFFFFFFC || log_addr[1] !== 32'h0 ||
                  log_be[0] !== 4'b1100 || log_be[1] !== 4'b0011) begin
      failures++; $display("FAIL wrap_beats got n=%0d want fffffffc/1100 then 0/0011", log_addr.size()); end
  endtask

  task automatic test_illegal();
    logic e1, e2, e3, r1, r2;
    @(negedge clk);
    req_we_i = 1'b0; req_size_i = 2'd2; req_unsigned_i = 1'b0; req_addr_i = 32'h101; req_rd_i = 5'd3;
    req_valid0 = 1'b1;
    @(negedge clk);
    e1 = err0; r1 = ready0;
    req_size_i = 2'd1; req_addr_i = 32'h201;
    @(negedge clk);
    e2 = err0; r2 = ready0;
    req_valid0 = 1'b0;
    @(negedge clk);
    e3 = err0;
    checks++; if (e1 !== 1'b1 || e2 !== 1'b1 || e3 !== 1'b0) begin failures++; $display("FAIL illegal_pulses got=%b%b%b want=110", e1, e2, e3); end
    checks++; if (r1 !== 1'b1 || r2 !== 1'b1) begin failures++; $display("FAIL illegal_ready got=%b%b want=11", r1, r2); end
    checks++; if ({mem_req0, mem_we0, mem_addr0, mem_be0, mem_wdata0, wb_valid0, wb_rd0, wb_data0} !== '0) begin
      failures++; $display("FAIL illegal_quiet got req=%b wbv=%b addr=%h want all zero", mem_req0, wb_valid0, mem_addr0); end
    clear_log();
    send(0, 1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 5'd3);
    @(negedge clk);
    e1 = err_misalign_o; r1 = req_ready_o;
    @(negedge clk);
    e2 = err_misalign_o;
    checks++; if (e1 !== 1'b1 || e2 !== 1'b0 || r1 !== 1'b1 || mem_req_o !== 1'b0 || log_addr.size() != 0) begin
      failures++; $display("FAIL dword_on_rv32 got err=%b%b ready=%b req=%b want 10/1/0", e1, e2, r1, mem_req_o); end
    send(1, 1'b0, 2'd1, 1'b0, 32'h202, 32'h0, 5'd3);
    @(negedge clk);
    checks++; if (err0 !== 1'b0 || mem_req0 !== 1'b1 || mem_addr0 !== 32'h200 || mem_be0 !== 4'b1100) begin
      failures++; $display("FAIL aligned_no_err got err=%b req=%b addr=%h be=%b want 0/1/200/1100", err0, mem_req0, mem_addr0, mem_be0); end
  endtask

  task automatic test_stall();
    logic wbv; logic [4:0] wrd; logic [31:0] wd; int wbk, cyc, errs; bit tmo;
    logic [31:0] d;
    set_lat(5, 5, 0, 0);
    unstable = 0;
    d = $urandom;
    ref_store(32'h111, 2'd1, d);
    send(0, 1'b1, 2'd1, 1'b0, 32'h111, d, 5'd0);
    wait_done(wbv, wrd, wd, wbk, cyc, errs, tmo);
    checks++; if (tmo || last_req_cycles != 6) begin failures++; $display("FAIL stall_req_cycles got=%0d want=6", last_req_cycles); end
    checks++; if (unstable != 0) begin failures++; $display("FAIL stall_stable got=%0d changes want=0", unstable); end
  endtask

  task automatic test_reset_mid();
    bit seen_wb, seen_err, seen_busy;
    set_lat(0, 0, 6, 6);
    send(0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 5'd3);
    for (int k = 0; k < 20 && !rv_pend; k++) @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (req_ready_o !== 1'b1 || {mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
                  wb_valid_o, wb_rd_o, wb_data_o, err_misalign_o} !== '0) begin
      failures++; $display("FAIL reset_mid_outputs got ready=%b req=%b addr=%h want 1 and zeros", req_ready_o, mem_req_o, mem_addr_o); end
    @(negedge clk);
    rst_n = 1'b1;
    seen_wb = 0; seen_err = 0; seen_busy = 0;
    repeat (12) begin
      @(negedge clk);
      if (wb_valid_o) seen_wb = 1;
      if (err_misalign_o) seen_err = 1;
      if (!req_ready_o) seen_busy = 1;
    end
    checks++; if (seen_wb || seen_err || seen_busy) begin
      failures++; $display("FAIL reset_mid_drop got wb=%0d err=%0d busy=%0d want 0/0/0", seen_wb, seen_err, seen_busy); end
  endtask

  task automatic test_random();
    logic wbv; logic [4:0] wrd; logic [31:0] wd; int wbk, cyc, errs; bit tmo;
    logic we, uns; logic [1:0] sz; logic [31:0] a, d, exp; logic [4:0] rd;
    set_lat(0, 3, 0, 3);
    unstable = 0; overlap = 0;
    for (int n = 0; n < 150; n++) begin
      we = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 2));
      uns = 1'($urandom_range(0, 1));
      a = 32'h200 + 32'($urandom_range(0, 63));
      d = $urandom;
      rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      exp = '0;
      if (we) ref_store(a, sz, d); else exp = ref_load(a, sz, uns);
      send(0, we, sz, uns, a, d, rd);
      wait_done(wbv, wrd, wd, wbk, cyc, errs, tmo);
      checks++; if (tmo || errs != 0) begin failures++; $display("FAIL rand_done op=%0d tmo=%0d errs=%0d want 0/0", n, tmo, errs); end
      if (!we && rd != 5'd0) begin
        checks++; if (!wbv || wrd !== rd || wd !== exp) begin
          failures++; $display("FAIL rand_load op=%0d a=%h sz=%0d u=%0d got wbv=%b rd=%0d data=%h want rd=%0d data=%h",
                               n, a, sz, uns, wbv, wrd, wd, rd, exp); end
      end else begin
        checks++; if (wbv) begin failures++; $display("FAIL rand_no_wb op=%0d we=%0d rd=%0d got wbv=1 want 0", n, we, rd); end
      end
    end
    checks++; if (overlap != 0 || unstable != 0) begin
      failures++; $display("FAIL rand_protocol got overlap=%0d unstable=%0d want 0/0", overlap, unstable); end
  endtask

  initial begin : main
    req_valid_i = 1'b0; req_valid0 = 1'b0; req_we_i = 1'b0; req_size_i = '0; req_unsigned_i = 1'b0;
    req_addr_i = '0; req_wdata_i = '0; req_rd_i = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_lw_timing();
    test_lb();
    test_store();
    test_lh_split();
    test_wrap();
    test_illegal();
    test_stall();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
